// File: rtl/sample_msg_combiner_pkg.sv
// Shared definitions for the sample/message combined stream format.
// The header layout and FSM encodings here are also used by sample_msg_splitter.
package sample_msg_combiner_pkg;

  localparam int DEF_WDTH              = 32;
  localparam int DEF_MSG_LENGTH_WDTH   = 8;
  localparam int DEF_BUFFER_LENGTH     = 64;
  localparam int DEF_LOG_BUFFER_LENGTH = 6;

  // Header flag is the word MSB; the payload length sits in the low bits.
  localparam int HDR_FLAG_BIT = DEF_WDTH - 1;
  localparam int LEN_MSB      = DEF_MSG_LENGTH_WDTH - 1;
  localparam int LEN_LSB      = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MSG  = 1'b1
  } state_t;

  function automatic logic is_header(input logic [DEF_WDTH-1:0] word);
    return word[HDR_FLAG_BIT];
  endfunction

  function automatic logic [DEF_MSG_LENGTH_WDTH-1:0] hdr_length(input logic [DEF_WDTH-1:0] word);
    return word[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/sample_msg_combiner_if.sv
// Stream bundle between a sample/message producer and the combiner.
interface sample_msg_combiner_if
  import sample_msg_combiner_pkg::*;
#(
  parameter int WDTH = DEF_WDTH
);
  logic [WDTH-1:0] in_samples;
  logic            in_samples_nd;
  logic [WDTH-1:0] in_msg;
  logic            in_msg_nd;
  logic [WDTH-1:0] out_data;
  logic            out_nd;

  modport master (
    output in_samples, in_samples_nd, in_msg, in_msg_nd,
    input  out_data, out_nd
  );

  modport slave (
    input  in_samples, in_samples_nd, in_msg, in_msg_nd,
    output out_data, out_nd
  );
endinterface

// File: rtl/sample_msg_combiner_buffer.sv
// Synchronous FIFO holding samples while a message owns the output.
// A write to a full FIFO is still taken when a read happens in the same cycle.
module sample_buffer
  import sample_msg_combiner_pkg::*;
#(
  parameter int WDTH              = DEF_WDTH,
  parameter int BUFFER_LENGTH     = DEF_BUFFER_LENGTH,
  parameter int LOG_BUFFER_LENGTH = DEF_LOG_BUFFER_LENGTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [WDTH-1:0] wr_data,
  input  logic            rd_en,
  output logic [WDTH-1:0] rd_data,
  output logic            empty,
  output logic            full
);

  logic [WDTH-1:0]              mem [BUFFER_LENGTH];
  logic [LOG_BUFFER_LENGTH-1:0] rd_ptr;
  logic [LOG_BUFFER_LENGTH-1:0] wr_ptr;
  logic [LOG_BUFFER_LENGTH:0]   count;
  logic                         do_rd;
  logic                         do_wr;

  assign empty   = (count == (LOG_BUFFER_LENGTH+1)'(0));
  assign full    = (count == (LOG_BUFFER_LENGTH+1)'(BUFFER_LENGTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // storage array, not reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + LOG_BUFFER_LENGTH'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + LOG_BUFFER_LENGTH'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + (LOG_BUFFER_LENGTH+1)'(1);
        2'b01:   count <= count - (LOG_BUFFER_LENGTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_msg_combiner.sv
// Merges a sample stream and a message stream onto one registered bus.
// Messages are never interleaved with samples; samples wait in sample_buffer.
module sample_msg_combiner
  import sample_msg_combiner_pkg::*;
#(
  parameter int WDTH              = DEF_WDTH,
  parameter int MSG_LENGTH_WDTH   = DEF_MSG_LENGTH_WDTH,
  parameter int BUFFER_LENGTH     = DEF_BUFFER_LENGTH,
  parameter int LOG_BUFFER_LENGTH = DEF_LOG_BUFFER_LENGTH
) (
  input  logic                  clk,
  input  logic                  reset,
  sample_msg_combiner_if.slave  bus,
  output logic                  error
);

  state_t                     state;
  logic [MSG_LENGTH_WDTH-1:0] remaining;
  logic [MSG_LENGTH_WDTH-1:0] hdr_len;
  logic                       msg_emit;
  logic                       msg_bad;
  logic                       sample_ok;
  logic                       sample_bad;
  logic                       bypass;
  logic                       rd_en;
  logic                       wr_en;
  logic                       drop_full;
  logic                       buf_empty;
  logic                       buf_full;
  logic [WDTH-1:0]            buf_data;

  assign hdr_len = bus.in_msg[MSG_LENGTH_WDTH-1:0];

  // classify this cycle's message and sample words
  always_comb begin
    msg_emit   = 1'b0;
    msg_bad    = 1'b0;
    sample_ok  = 1'b0;
    sample_bad = 1'b0;
    if (bus.in_msg_nd) begin
      if ((state == ST_MSG) || bus.in_msg[WDTH-1]) begin
        msg_emit = 1'b1;
      end else begin
        msg_bad = 1'b1;
      end
    end else begin
      msg_emit = 1'b0;
    end
    if (bus.in_samples_nd) begin
      if (bus.in_samples[WDTH-1]) begin
        sample_bad = 1'b1;
      end else begin
        sample_ok = 1'b1;
      end
    end else begin
      sample_ok = 1'b0;
    end
  end

  // a sample skips the buffer only when nothing older or higher-priority exists
  assign bypass    = sample_ok && (state == ST_IDLE) && buf_empty && !bus.in_msg_nd;
  assign rd_en     = (state == ST_IDLE) && !buf_empty && !msg_emit;
  assign wr_en     = sample_ok && !bypass;
  assign drop_full = wr_en && buf_full && !rd_en;

  sample_buffer #(
    .WDTH              (WDTH),
    .BUFFER_LENGTH     (BUFFER_LENGTH),
    .LOG_BUFFER_LENGTH (LOG_BUFFER_LENGTH)
  ) u_buffer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (bus.in_samples),
    .rd_en   (rd_en),
    .rd_data (buf_data),
    .empty   (buf_empty),
    .full    (buf_full)
  );

  // message FSM with registered output slot and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      bus.out_nd   <= 1'b0;
      bus.out_data <= '0;
      error        <= 1'b0;
    end else begin
      bus.out_nd <= msg_emit || bypass || rd_en;
      if (msg_emit) begin
        bus.out_data <= bus.in_msg;
      end else if (bypass) begin
        bus.out_data <= bus.in_samples;
      end else if (rd_en) begin
        bus.out_data <= buf_data;
      end else begin
        bus.out_data <= bus.out_data;
      end
      if (msg_bad || sample_bad || drop_full) begin
        error <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (msg_emit && (hdr_len != MSG_LENGTH_WDTH'(0))) begin
            state     <= ST_MSG;
            remaining <= hdr_len;
          end
        end
        ST_MSG: begin
          if (msg_emit) begin
            remaining <= remaining - MSG_LENGTH_WDTH'(1);
            if (remaining == MSG_LENGTH_WDTH'(1)) begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          remaining <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_msg_combiner.sv
// Directed self-checking bench for sample_msg_combiner.
module tb_sample_msg_combiner;
  import sample_msg_combiner_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        error;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] outq [$];
  logic [31:0] expq [$];

  always #5 clk = ~clk;

  sample_msg_combiner_if #(.WDTH(32)) bus ();

  sample_msg_combiner dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .error (error)
  );

  // collect every emitted word, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.out_nd === 1'b1) outq.push_back(bus.out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic snd, input logic [31:0] s, input logic mnd, input logic [31:0] m);
    @(negedge clk);
    bus.in_samples_nd = snd;
    bus.in_samples    = s;
    bus.in_msg_nd     = mnd;
    bus.in_msg        = m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_count"}, 32'(outq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < outq.size(); i++)
      check($sformatf("%s[%0d]", tag, i), outq[i], expq[i]);
    outq.delete();
    expq.delete();
  endtask

  initial begin
    reset             = 1'b1;
    bus.in_samples    = 32'h0;
    bus.in_samples_nd = 1'b0;
    bus.in_msg        = 32'h0;
    bus.in_msg_nd     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_nd", {31'h0, bus.out_nd}, 32'h0);
    check("reset_out_data", bus.out_data, 32'h0);
    check("reset_error", {31'h0, error}, 32'h0);
    reset = 1'b0;

    // plain samples, 1-cycle bypass latency
    drive(1'b1, 32'h1, 1'b0, 32'h0);
    drive(1'b1, 32'h2, 1'b0, 32'h0);
    check("t1_nd", {31'h0, bus.out_nd}, 32'h1);
    check("t1_d1", bus.out_data, 32'h1);
    drive(1'b1, 32'h3, 1'b0, 32'h0);
    check("t1_d2", bus.out_data, 32'h2);
    idle(1);
    check("t1_d3", bus.out_data, 32'h3);
    idle(4);
    check("t1_error", {31'h0, error}, 32'h0);
    expq = '{32'h1, 32'h2, 32'h3};
    compare_q("t1");

    // message wins the slot, samples follow in order
    drive(1'b1, 32'hA, 1'b1, 32'h8000_0002);
    drive(1'b1, 32'hB, 1'b1, 32'hFFFF_FFFF);
    drive(1'b1, 32'hC, 1'b1, 32'h0000_0005);
    idle(6);
    expq = '{32'h8000_0002, 32'hFFFF_FFFF, 32'h5, 32'hA, 32'hB, 32'hC};
    compare_q("t2");
    check("t2_error", {31'h0, error}, 32'h0);

    // gapped payload, samples held until after the last payload word
    drive(1'b0, 32'h0, 1'b1, 32'h8000_0003);
    for (int p = 0; p < 3; p++) begin
      for (int g = 0; g < 3; g++) drive(1'b1, 32'h11 + 32'(3 * p + g), 1'b0, 32'h0);
      drive(1'b0, 32'h0, 1'b1, 32'h101 + 32'(p));
    end
    idle(12);
    expq = '{32'h8000_0003, 32'h101, 32'h102, 32'h103};
    for (int i = 0; i < 9; i++) expq.push_back(32'h11 + 32'(i));
    compare_q("t3");

    // zero-length header keeps FSM idle, next sample bypasses
    drive(1'b0, 32'h0, 1'b1, 32'h8000_0000);
    drive(1'b1, 32'h7, 1'b0, 32'h0);
    check("t4_state", 32'(dut.state), 32'(ST_IDLE));
    idle(1);
    check("t4_sample", bus.out_data, 32'h7);
    idle(3);
    expq = '{32'h8000_0000, 32'h7};
    compare_q("t4");

    // overflow: 65th sample dropped during a long message
    drive(1'b0, 32'h0, 1'b1, 32'h8000_0064);
    for (int i = 0; i < 64; i++) drive(1'b1, 32'h200 + 32'(i), 1'b0, 32'h0);
    drive(1'b1, 32'h2FF, 1'b0, 32'h0);
    check("t5_error_before", {31'h0, error}, 32'h0);
    idle(1);
    check("t5_error_set", {31'h0, error}, 32'h1);
    for (int i = 0; i < 100; i++) drive(1'b0, 32'h0, 1'b1, 32'h1000 + 32'(i));
    idle(70);
    check("t5_error_sticky", {31'h0, error}, 32'h1);
    expq = '{32'h8000_0064};
    for (int i = 0; i < 100; i++) expq.push_back(32'h1000 + 32'(i));
    for (int i = 0; i < 64; i++) expq.push_back(32'h200 + 32'(i));
    compare_q("t5");

    // bad sample, then bad idle message word
    do_reset();
    check("t6_error_clr", {31'h0, error}, 32'h0);
    drive(1'b1, 32'h8000_0001, 1'b0, 32'h0);
    idle(1);
    check("t6_bad_sample", {31'h0, error}, 32'h1);
    idle(2);
    compare_q("t6_bad_sample_out");
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0004);
    idle(1);
    check("t6_bad_msg", {31'h0, error}, 32'h1);
    idle(2);
    compare_q("t6_bad_msg_out");

    // reset mid-message with buffered samples
    drive(1'b0, 32'h0, 1'b1, 32'h8000_0005);
    drive(1'b1, 32'h51, 1'b1, 32'h301);
    drive(1'b1, 32'h52, 1'b1, 32'h302);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.in_samples_nd = 1'b1;
    bus.in_samples    = 32'h42;
    check("t6_rst_out_nd", {31'h0, bus.out_nd}, 32'h0);
    check("t6_rst_error", {31'h0, error}, 32'h0);
    expq = '{32'h8000_0005, 32'h301, 32'h302};
    compare_q("t6_pre_reset");
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check("t6_bypass_nd", {31'h0, bus.out_nd}, 32'h1);
    check("t6_bypass_data", bus.out_data, 32'h42);
    idle(4);
    expq = '{32'h42};
    compare_q("t6_post_reset");

    // full buffer accepts a write in the same cycle as a read
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 32'h8000_0001);
    for (int i = 0; i < 64; i++) drive(1'b1, 32'h400 + 32'(i), 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 32'h777);
    drive(1'b1, 32'h4FF, 1'b0, 32'h0);
    idle(1);
    check("t7_error_boundary", {31'h0, error}, 32'h0);
    idle(70);
    check("t7_error_end", {31'h0, error}, 32'h0);
    expq = '{32'h8000_0001, 32'h777};
    for (int i = 0; i < 64; i++) expq.push_back(32'h400 + 32'(i));
    expq.push_back(32'h4FF);
    compare_q("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
